// File: rtl/pc_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_if
//   Bundles the fetch unit's datapath-facing signals: the PC adder result,
//   jump/branch redirects, the decode stall, the instruction memory response
//   and the fetch unit's outputs.
//
//   Modports:
//     master - the surrounding datapath / memory / testbench side
//     slave  - the pc_fetch_unit side
//
//   Signals (direction as seen by the fetch unit):
//     nxt_pc         in  32  sequential next PC (pc+4) from the adder
//     jump           in   1  jump redirect request
//     jump_target    in  32  jump destination
//     branch_taken   in   1  taken-branch redirect request
//     branch_target  in  32  branch destination
//     stall          in   1  decode cannot accept the delivered instruction
//     inst_rdata     in  32  instruction word from instruction memory
//     inst_rvalid    in   1  memory response valid for the current request
//     pc             out 32  current PC
//     inst_ce        out  1  instruction memory / adder enable
//     inst_addr      out 32  fetch address (equals pc)
//     inst_o         out 32  registered instruction to decode
//     inst_valid     out  1  inst_o holds the instruction for the current pc
//     misalign_err   out  1  sticky misaligned-redirect flag
// ---------------------------------------------------------------------------
interface pc_fetch_unit_if;

    logic [31:0] nxt_pc;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic [31:0] inst_rdata;
    logic        inst_rvalid;

    logic [31:0] pc;
    logic        inst_ce;
    logic [31:0] inst_addr;
    logic [31:0] inst_o;
    logic        inst_valid;
    logic        misalign_err;

    modport master (
        output nxt_pc,
        output jump,
        output jump_target,
        output branch_taken,
        output branch_target,
        output stall,
        output inst_rdata,
        output inst_rvalid,
        input  pc,
        input  inst_ce,
        input  inst_addr,
        input  inst_o,
        input  inst_valid,
        input  misalign_err
    );

    modport slave (
        input  nxt_pc,
        input  jump,
        input  jump_target,
        input  branch_taken,
        input  branch_target,
        input  stall,
        input  inst_rdata,
        input  inst_rvalid,
        output pc,
        output inst_ce,
        output inst_addr,
        output inst_o,
        output inst_valid,
        output misalign_err
    );

endinterface

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//   Program-counter register and instruction-fetch sequencer. Holds the
//   current PC, requests the instruction at that PC from instruction memory,
//   presents the returned word to decode with a valid/stall handshake and
//   then advances the PC to the adder result or to a jump/branch target.
//
//   Ports:
//     clk  in   system clock, rising-edge active
//     rst  in   synchronous, active-high reset
//     bus  slave modport of pc_fetch_unit_if (see that file for signals)
//
//   Parameters:
//     RESET_PC  PC loaded on reset; must be word aligned.
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    pc_fetch_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDeliver
    } state_e;

    state_e      state_q,      state_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] inst_q,       inst_d;
    logic        inst_valid_q, inst_valid_d;
    logic        misalign_q,   misalign_d;

    // Redirect selection: jump wins over branch.
    logic        redirect;
    logic [31:0] redirect_target;

    always_comb begin
        redirect        = 1'b0;
        redirect_target = 32'h0000_0000;
        if (bus.jump) begin
            redirect        = 1'b1;
            redirect_target = bus.jump_target;
        end else if (bus.branch_taken) begin
            redirect        = 1'b1;
            redirect_target = bus.branch_target;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        misalign_d   = misalign_q;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end

            StReq: begin
                if (bus.inst_rvalid) begin
                    inst_d       = bus.inst_rdata;
                    inst_valid_d = 1'b1;
                    state_d      = StDeliver;
                end
            end

            StDeliver: begin
                // A stalled decode freezes everything, including redirects.
                if (!bus.stall) begin
                    inst_valid_d = 1'b0;
                    state_d      = StReq;
                    if (redirect) begin
                        // Misaligned targets are forced onto a word boundary.
                        pc_d = {redirect_target[31:2], 2'b00};
                        if (redirect_target[1:0] != 2'b00) begin
                            misalign_d = 1'b1;
                        end
                    end else begin
                        pc_d = bus.nxt_pc;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0000_0000;
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            misalign_q   <= misalign_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.inst_addr    = pc_q;
    assign bus.inst_ce      = (state_q == StReq);
    assign bus.inst_o       = inst_q;
    assign bus.inst_valid   = inst_valid_q;
    assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    // Reference model state: where the PC should be and whether a
    // misaligned redirect has been seen since the last reset.
    logic [31:0] exp_pc;
    logic        exp_err;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // The PC adder of the surrounding datapath.
    assign bus.nxt_pc = bus.pc + 32'd4;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle zero-wait memory response from REQ into DELIVER.
    task automatic give_word(input logic [31:0] word);
        bus.inst_rvalid = 1'b1;
        bus.inst_rdata  = word;
        tick();
        bus.inst_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.pc, bus.inst_o} !== 64'h0) begin
            failures++;
            $display("FAIL reset_pc_inst got=%h required=%h", {bus.pc, bus.inst_o}, 64'h0);
        end
        checks++;
        if ({bus.inst_valid, bus.inst_ce, bus.misalign_err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b required=000",
                     {bus.inst_valid, bus.inst_ce, bus.misalign_err});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({bus.inst_ce, bus.inst_valid, bus.pc} !== {1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL first_ce got=%h required=%h",
                     {bus.inst_ce, bus.inst_valid, bus.pc}, {1'b1, 1'b0, 32'h0});
        end
        exp_pc  = 32'h0;
        exp_err = 1'b0;
    endtask

    task automatic test_zero_wait();
        logic [31:0] words [2];
        words[0] = 32'h2008_0001;
        words[1] = 32'h2009_0002;
        for (int k = 0; k < 2; k++) begin
            give_word(words[k]);
            checks++;
            if ({bus.inst_valid, bus.inst_ce, bus.pc, bus.inst_o} !==
                {1'b1, 1'b0, exp_pc, words[k]}) begin
                failures++;
                $display("FAIL zw_deliver%0d got=%h required=%h", k,
                         {bus.inst_valid, bus.inst_ce, bus.pc, bus.inst_o},
                         {1'b1, 1'b0, exp_pc, words[k]});
            end
            tick();
            exp_pc = exp_pc + 32'd4;
            checks++;
            if ({bus.inst_valid, bus.inst_ce, bus.pc} !== {1'b0, 1'b1, exp_pc}) begin
                failures++;
                $display("FAIL zw_advance%0d got=%h required=%h", k,
                         {bus.inst_valid, bus.inst_ce, bus.pc}, {1'b0, 1'b1, exp_pc});
            end
        end
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.inst_ce, bus.inst_valid, bus.pc, bus.inst_addr} !==
                {1'b1, 1'b0, exp_pc, exp_pc}) begin
                failures++;
                $display("FAIL wait_req%0d got=%h required=%h", i,
                         {bus.inst_ce, bus.inst_valid, bus.pc, bus.inst_addr},
                         {1'b1, 1'b0, exp_pc, exp_pc});
            end
            bus.inst_rvalid = (i == 3);
            bus.inst_rdata  = 32'hCAFE_0003;
            tick();
        end
        bus.inst_rvalid = 1'b0;
        checks++;
        if ({bus.inst_valid, bus.inst_o} !== {1'b1, 32'hCAFE_0003}) begin
            failures++;
            $display("FAIL wait_deliver got=%h required=%h",
                     {bus.inst_valid, bus.inst_o}, {1'b1, 32'hCAFE_0003});
        end
        tick();
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic test_stall();
        give_word(32'h5A5A_1234);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({bus.inst_valid, bus.inst_ce, bus.pc, bus.inst_o} !==
                {1'b1, 1'b0, exp_pc, 32'h5A5A_1234}) begin
                failures++;
                $display("FAIL stall_hold%0d got=%h required=%h", i,
                         {bus.inst_valid, bus.inst_ce, bus.pc, bus.inst_o},
                         {1'b1, 1'b0, exp_pc, 32'h5A5A_1234});
            end
            bus.stall       = (i < 5);
            bus.jump        = (i == 2);
            bus.jump_target = 32'h0000_0300;
            tick();
        end
        bus.stall = 1'b0;
        bus.jump  = 1'b0;
        exp_pc = exp_pc + 32'd4;
        checks++;
        if ({bus.inst_valid, bus.inst_ce, bus.pc} !== {1'b0, 1'b1, exp_pc}) begin
            failures++;
            $display("FAIL stall_release got=%h required=%h",
                     {bus.inst_valid, bus.inst_ce, bus.pc}, {1'b0, 1'b1, exp_pc});
        end
    endtask

    task automatic test_priority();
        give_word(32'h1111_2222);
        bus.jump          = 1'b1;
        bus.jump_target   = 32'h0000_0100;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0200;
        tick();
        bus.jump         = 1'b0;
        bus.branch_taken = 1'b0;
        exp_pc = 32'h0000_0100;
        checks++;
        if ({bus.pc, bus.misalign_err} !== {exp_pc, exp_err}) begin
            failures++;
            $display("FAIL priority got=%h required=%h",
                     {bus.pc, bus.misalign_err}, {exp_pc, exp_err});
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int unsigned w = $urandom_range(0, 3);
            int unsigned s = $urandom_range(0, 3);
            int unsigned kind = $urandom_range(0, 3);
            logic [31:0] word = $urandom;
            logic [31:0] jt = $urandom;
            logic [31:0] bt = $urandom;
            logic [31:0] sel;
            if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            // Request phase: w wait cycles with ignored redirect noise.
            for (int i = 0; i <= w; i++) begin
                checks++;
                if ({bus.inst_ce, bus.inst_valid, bus.pc, bus.inst_addr, bus.misalign_err} !==
                    {1'b1, 1'b0, exp_pc, exp_pc, exp_err}) begin
                    failures++;
                    $display("FAIL rnd_req n=%0d got=%h required=%h", n,
                             {bus.inst_ce, bus.inst_valid, bus.pc, bus.inst_addr,
                              bus.misalign_err}, {1'b1, 1'b0, exp_pc, exp_pc, exp_err});
                end
                bus.inst_rvalid  = (i == w);
                bus.inst_rdata   = (i == w) ? word : $urandom;
                bus.jump         = 1'($urandom);
                bus.branch_taken = 1'($urandom);
                tick();
            end
            // Delivery phase: s stalled cycles, then the release cycle.
            for (int j = 0; j <= s; j++) begin
                checks++;
                if ({bus.inst_valid, bus.inst_ce, bus.pc, bus.inst_o} !==
                    {1'b1, 1'b0, exp_pc, word}) begin
                    failures++;
                    $display("FAIL rnd_deliver n=%0d got=%h required=%h", n,
                             {bus.inst_valid, bus.inst_ce, bus.pc, bus.inst_o},
                             {1'b1, 1'b0, exp_pc, word});
                end
                bus.inst_rvalid   = 1'($urandom);
                bus.inst_rdata    = $urandom;
                bus.stall         = (j < s);
                bus.jump          = (j < s) ? 1'($urandom) : kind[0];
                bus.branch_taken  = (j < s) ? 1'($urandom) : kind[1];
                bus.jump_target   = jt;
                bus.branch_target = bt;
                tick();
            end
            bus.stall = 1'b0;
            if (kind[0] || kind[1]) begin
                sel = kind[0] ? jt : bt;
                if (sel % 4 != 0) exp_err = 1'b1;
                exp_pc = sel - (sel % 4);
            end else begin
                exp_pc = exp_pc + 32'd4;
            end
        end
        bus.inst_rvalid  = 1'b0;
        bus.jump         = 1'b0;
        bus.branch_taken = 1'b0;
        checks++;
        if ({bus.pc, bus.misalign_err} !== {exp_pc, exp_err}) begin
            failures++;
            $display("FAIL rnd_end got=%h required=%h",
                     {bus.pc, bus.misalign_err}, {exp_pc, exp_err});
        end
    endtask

    task automatic test_misalign();
        give_word(32'h3333_4444);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0046;
        tick();
        bus.branch_taken = 1'b0;
        exp_pc  = 32'h0000_0044;
        exp_err = 1'b1;
        checks++;
        if ({bus.pc, bus.misalign_err} !== {exp_pc, exp_err}) begin
            failures++;
            $display("FAIL misalign got=%h required=%h",
                     {bus.pc, bus.misalign_err}, {exp_pc, exp_err});
        end
        give_word(32'h5555_6666);
        tick();
        exp_pc = exp_pc + 32'd4;
        checks++;
        if ({bus.pc, bus.misalign_err} !== {exp_pc, 1'b1}) begin
            failures++;
            $display("FAIL misalign_sticky got=%h required=%h",
                     {bus.pc, bus.misalign_err}, {exp_pc, 1'b1});
        end
    endtask

    task automatic test_wrap();
        give_word(32'h7777_8888);
        bus.jump        = 1'b1;
        bus.jump_target = 32'hFFFF_FFFC;
        tick();
        bus.jump = 1'b0;
        checks++;
        if (bus.pc !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_jump got=%h required=%h", bus.pc, 32'hFFFF_FFFC);
        end
        give_word(32'h9999_AAAA);
        tick();
        exp_pc = 32'h0000_0000;
        checks++;
        if ({bus.pc, bus.misalign_err, bus.inst_ce} !== {exp_pc, exp_err, 1'b1}) begin
            failures++;
            $display("FAIL wrap_seq got=%h required=%h",
                     {bus.pc, bus.misalign_err, bus.inst_ce}, {exp_pc, exp_err, 1'b1});
        end
    endtask

    task automatic test_reset_in_req();
        // Move somewhere non-zero first so the reset visibly reloads the PC.
        give_word(32'hBBBB_CCCC);
        tick();
        bus.inst_rvalid = 1'b1;
        bus.inst_rdata  = 32'hDEAD_BEEF;
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.pc, bus.inst_o, bus.inst_valid, bus.inst_ce, bus.misalign_err} !==
            {32'h0, 32'h0, 3'b000}) begin
            failures++;
            $display("FAIL rst_in_req got=%h required=%h",
                     {bus.pc, bus.inst_o, bus.inst_valid, bus.inst_ce, bus.misalign_err},
                     {32'h0, 32'h0, 3'b000});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({bus.inst_o, bus.inst_valid, bus.inst_ce} !== {32'h0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL rst_late_rvalid got=%h required=%h",
                     {bus.inst_o, bus.inst_valid, bus.inst_ce}, {32'h0, 1'b0, 1'b1});
        end
        bus.inst_rvalid = 1'b0;
    endtask

    initial begin
        bus.jump          = 1'b0;
        bus.jump_target   = 32'h0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        bus.stall         = 1'b0;
        bus.inst_rdata    = 32'h0;
        bus.inst_rvalid   = 1'b0;
        exp_pc            = 32'h0;
        exp_err           = 1'b0;

        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_priority();
        test_random();
        test_misalign();
        test_wrap();
        test_reset_in_req();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter register and instruction-fetch sequencer for the single-cycle CPU datapath. Holds the current PC and drives it to the PC+4 adder and instruction memory. It then loads the next PC from the adder's nxt_pc, or from a jump or branch target. It also controls inst_ce and presents each fetched instruction to decode with a valid/stall handshake.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
nxt_pc  input  32  sequential next PC (pc+4) from the PC adder.
jump  input  1  jump redirect request, sampled only in DELIVER with stall=0.
jump_target  input  32  jump destination.
branch_taken  input  1  taken-branch redirect, sampled only in DELIVER with stall=0.
branch_target  input  32  branch destination.
stall  input  1  decode cannot accept the delivered instruction; hold everything.
inst_rdata  input  32  instruction word from instruction memory.
inst_rvalid  input  1  memory returns inst_rdata for the current request; may be high in the same cycle as inst_ce.
pc  output  32  current PC; feeds the adder cur_pc input.
inst_ce  output  1  instruction memory / adder enable.
inst_addr  output  32  fetch address; always equals pc.
inst_o  output  32  registered instruction to decode.
inst_valid  output  1  inst_o holds a new instruction for the current pc.
misalign_err  output  1  sticky flag: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset, at a clock edge with rst=1, regardless of state:
  - pc=RESET_PC, inst_o=0, inst_valid=0, inst_ce=0, misalign_err=0, state=IDLE.
  - An outstanding fetch is abandoned. A late inst_rvalid is ignored because the FSM is not in REQ.
- FSM states: IDLE, REQ, DELIVER.
- IDLE:
  - inst_ce=0.
  - Unconditionally moves to REQ next cycle, so the first inst_ce is in the first cycle after rst deasserts.
- REQ:
  - inst_ce=1 (combinational decode of state); inst_addr=pc; pc held.
  - On inst_rvalid=1: inst_o<=inst_rdata, inst_valid<=1, state<=DELIVER.
  - Otherwise remain in REQ indefinitely, since there is no timeout.
- DELIVER:
  - inst_ce=0; inst_valid=1; inst_o and pc held.
  - If stall=1: remain in DELIVER and hold everything. Redirect inputs are ignored in that cycle.
  - If stall=0: inst_valid<=0, state<=REQ, and pc loads the next-PC select with priority jump > branch_taken > nxt_pc.
- nxt_pc contract: the adder updates nxt_pc while inst_ce=1 and pc is stable, so nxt_pc equals pc+4 in DELIVER.
- Redirect alignment:
  - If the selected redirect target has bits [1:0] != 0, pc loads {target[31:2],2'b00} and misalign_err<=1.
  - misalign_err stays set until rst. nxt_pc is never checked.
- Wrap-around: pc arithmetic is modulo 2^32, so nxt_pc=32'h0000_0000 after 32'hFFFF_FFFC is loaded as-is.
- Inputs outside their sampling state are ignored: inst_rvalid outside REQ, and jump/branch_taken outside DELIVER with stall=0.
- Timing: throughput is 1 instruction per 2 cycles with zero-wait memory. Latency from rst deassert to the first inst_valid is 2 cycles with zero-wait memory, plus N for N wait cycles.
- Outputs pc, inst_o, inst_valid and misalign_err are registered. inst_ce and inst_addr are derived from state and pc.

Test Plan:
1. Reset, then zero-wait memory returning 32'h2008_0001 at pc 0 and 32'h2009_0002 at pc 4, stall=0 -> inst_ce high in cycle 1; inst_valid in cycle 2 with inst_o=32'h2008_0001, pc=0; pc=4 in cycle 3; second instruction valid in cycle 4.
2. inst_rvalid delayed 3 cycles in REQ -> inst_ce stays high and pc stays constant for 4 cycles; inst_valid rises the cycle after rvalid.
3. stall=1 for 5 cycles in DELIVER with jump=1 pulsed mid-stall -> inst_o, pc and inst_valid held; jump ignored; after stall drops, pc=nxt_pc.
4. In DELIVER with stall=0, jump=1 (jump_target=32'h0000_0100) and branch_taken=1 (branch_target=32'h0000_0200) together -> pc=32'h0000_0100.
5. branch_taken with branch_target=32'h0000_0046 -> pc=32'h0000_0044 and misalign_err=1, held through later fetches until rst.
6. rst asserted while in REQ with inst_rvalid arriving the same cycle -> pc=RESET_PC, inst_valid=0, state IDLE; inst_o stays 0.
